// File: rtl/mult_seq32_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mult_seq32_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MUL_CYCLES = 32;
   localparam logic [5:0] LAST_ITER = 6'(MUL_CYCLES - 1);

endpackage

// File: rtl/mult_seq32_adder32.sv
// Ripple-carry adder used by the shift-add multiplier datapath.
module mult_seq32_adder32 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic c;

   always_comb begin
      c = cin;
      sum = '0;
      for (int i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/mult_seq32.sv
// Sequential shift-add unsigned multiplier, one partial product per cycle.
module mult_seq32
   import mult_seq32_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [WIDTH-1:0]   DataA,
   input  logic [WIDTH-1:0]   DataB,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] Product,
   output logic               HiNonZero
);

   state_t           state;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] radd;
   logic             carry;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;

   assign addend = acc_lo[0] ? mcand : '0;

   mult_seq32_adder32 #(
      .W(WIDTH)
   ) u_add (
      .a    (acc_hi),
      .b    (addend),
      .cin  (1'b0),
      .sum  (radd),
      .cout (carry)
   );

   // Shift the 65-bit {carry, sum, acc_lo} right by one.
   assign nxt_hi = {carry, radd[WIDTH-1:1]};
   assign nxt_lo = {radd[0], acc_lo[WIDTH-1:1]};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mcand     <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Product   <= '0;
         HiNonZero <= 1'b0;
      end else begin
         Done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (Start) begin
                  mcand  <= DataA;
                  acc_hi <= '0;
                  acc_lo <= DataB;
                  cnt    <= '0;
                  Busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               cnt    <= cnt + 6'd1;
               if (cnt == LAST_ITER) begin
                  Product   <= {nxt_hi, nxt_lo};
                  HiNonZero <= |nxt_hi;
                  Done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq32.sv
// Self-checking bench for mult_seq32: vector table, random, corner sequences.
module tb_mult_seq32;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [31:0] DataA = '0;
   logic [31:0] DataB = '0;
   logic        Busy;
   logic        Done;
   logic [63:0] Product;
   logic        HiNonZero;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_q[$];

   mult_seq32 #(.WIDTH(32)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .DataA     (DataA),
      .DataB     (DataB),
      .Busy      (Busy),
      .Done      (Done),
      .Product   (Product),
      .HiNonZero (HiNonZero)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (Done) begin
         done_cnt <= done_cnt + 1;
         done_q.push_back(cyc);
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] prod;
      logic        hnz;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] ep, input logic eh,
                          input string tag);
      int lat;
      bit seen;
      logic [63:0] prev;
      prev = Product;
      @(negedge Clk);
      Start = 1'b1;
      DataA = a;
      DataB = b;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      DataA = $urandom;
      DataB = $urandom;
      chk({tag, "_busy_run"}, 64'(Busy), 64'd1);
      lat = 0;
      seen = 0;
      while (!seen && lat < 100) begin
         @(posedge Clk);
         #1;
         lat++;
         if (lat == 16) chk({tag, "_hold"}, Product, prev);
         if (Done) seen = 1;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd32);
      chk({tag, "_product"}, Product, ep);
      chk({tag, "_hinz"}, 64'(HiNonZero), 64'(eh));
      @(posedge Clk);
      #1;
      chk({tag, "_done_pulse"}, 64'(Done), 64'd0);
      chk({tag, "_busy_idle"}, 64'(Busy), 64'd0);
   endtask

   initial begin
      vec_t vt[8];
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] rp;
      int dc;

      vt[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0};
      vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1};
      vt[2] = '{32'h0, 32'h1234_5678, 64'h0, 1'b0};
      vt[3] = '{32'h1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0};
      vt[4] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1};
      vt[5] = '{32'h8000_0000, 32'h2, 64'h0000_0001_0000_0000, 1'b1};
      vt[6] = '{32'hFFFF_FFFF, 32'h0, 64'h0, 1'b0};
      vt[7] = '{32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780, 1'b1};

      #1;
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_done", 64'(Done), 64'd0);
      chk("rst_product", Product, 64'd0);
      chk("rst_hinz", 64'(HiNonZero), 64'd0);
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;

      for (int i = 0; i < 8; i++)
         run_mul(vt[i].a, vt[i].b, vt[i].prod, vt[i].hnz,
                 $sformatf("vec%0d", i));

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 0) ra = ra >> (i % 31);
         rp = 64'(ra) * 64'(rb);
         run_mul(ra, rb, rp, rp[63:32] != 0, $sformatf("rnd%0d", i));
      end

      // Start held through RUN: must be ignored, one result only.
      dc = done_cnt;
      @(negedge Clk);
      Start = 1'b1;
      DataA = 32'd9;
      DataB = 32'd11;
      @(posedge Clk);
      #1;
      DataA = 32'd1000;
      DataB = 32'd1000;
      repeat (20) @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (30) @(posedge Clk);
      #1;
      chk("ignore_done_count", 64'(done_cnt - dc), 64'd1);
      chk("ignore_product", Product, 64'd99);

      // Continuous Start: a new multiply every 34 cycles.
      @(negedge Clk);
      done_q.delete();
      Start = 1'b1;
      DataA = 32'd100;
      DataB = 32'd200;
      repeat (34 * 5) @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (40) @(posedge Clk);
      #1;
      chk("held_count", 64'(done_q.size() >= 4), 64'd1);
      for (int i = 1; i < done_q.size(); i++)
         chk($sformatf("held_period%0d", i),
             64'(done_q[i] - done_q[i-1]), 64'd34);
      chk("held_product", Product, 64'd20000);

      // Reset ten cycles into RUN discards the multiply.
      @(negedge Clk);
      Start = 1'b1;
      DataA = 32'hFFFF_FFFF;
      DataB = 32'hFFFF_FFFF;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (10) @(posedge Clk);
      #1;
      dc = done_cnt;
      Reset = 1'b1;
      #1;
      chk("midrst_busy", 64'(Busy), 64'd0);
      chk("midrst_product", Product, 64'd0);
      chk("midrst_hinz", 64'(HiNonZero), 64'd0);
      chk("midrst_done", 64'(Done), 64'd0);
      Start = 1'b1;
      DataA = 32'd5;
      DataB = 32'd5;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_start_ignored", 64'(Busy), 64'd0);
      @(negedge Clk);
      Reset = 1'b0;
      Start = 1'b0;
      repeat (40) @(posedge Clk);
      #1;
      chk("midrst_no_done", 64'(done_cnt - dc), 64'd0);
      chk("midrst_idle", 64'(Busy), 64'd0);
      run_mul(32'd7, 32'd6, 64'd42, 1'b0, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
